falafel_mem_responder: RTL and testbench

Word-addressed memory model that acts as the responder on the falafel memory request/response interface. The allocator LSU drives it as the initiator. It accepts one request at a time, commits writes, returns read data after a configurable latency, and holds each response until the initiator takes it. It serves as the backing store for allocator simulation and as the memory endpoint in the top-level integration bench.

---
 rtl/falafel_pkg.sv | 23 ++
 rtl/falafel_sram.sv | 26 ++
 rtl/falafel_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_falafel_mem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/falafel_pkg.sv
// Shared types and constants for the falafel allocator memory system.
package falafel_pkg;

  localparam int DATA_W              = 32;
  localparam int WORD_SIZE           = DATA_W / 8;
  localparam int MEM_DEFAULT_LATENCY = 2;

  typedef logic [DATA_W-1:0] word_t;

  localparam word_t NULL_PTR = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } rsp_state_e;

  typedef struct packed {
    logic  invalid;
    word_t index;
  } mem_decode_t;

endpackage

// File: rtl/falafel_sram.sv
// Single-port word store: synchronous write, combinational read, no array reset.
module falafel_sram
  import falafel_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t mem [WORDS];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/falafel_mem_responder.sv
// Memory responder for the falafel request/response interface: one outstanding
// transaction, writes committed at acceptance, response after LATENCY wait cycles.
module falafel_mem_responder
  import falafel_pkg::*;
#(
  parameter int    MEM_WORDS = 1024,
  parameter word_t BASE_ADDR = '0,
  parameter int    LATENCY   = MEM_DEFAULT_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_req_val_i,
  output logic              mem_req_rdy_o,
  input  logic              mem_req_is_write_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  output logic              mem_rsp_val_o,
  input  logic              mem_rsp_rdy_i,
  output logic [DATA_W-1:0] mem_rsp_data_o,
  output logic              err_o
);

  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Below-base addresses are caught before the subtraction so the offset never wraps.
  function automatic mem_decode_t decode(input word_t addr);
    mem_decode_t d;
    logic        below;
    word_t       offset;
    below     = (addr < BASE_ADDR);
    offset    = below ? word_t'(0) : (addr - BASE_ADDR);
    d.index   = offset / word_t'(WORD_SIZE);
    d.invalid = below
             || ((offset % word_t'(WORD_SIZE)) != word_t'(0))
             || (d.index >= word_t'(MEM_WORDS));
    return d;
  endfunction

  function automatic word_t rsp_value(input logic wr, input logic invalid,
                                      input word_t wdata, input word_t rdata);
    if (invalid) begin
      return NULL_PTR;
    end else if (wr) begin
      return wdata;
    end else begin
      return rdata;
    end
  endfunction

  rsp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_write_q, is_write_d;
  word_t            addr_q, addr_d;
  word_t            data_q, data_d;
  word_t            rsp_data_q, rsp_data_d;
  logic             err_q, err_d;

  mem_decode_t      req_dec, cur_dec;
  logic             accept;
  logic             sram_we;
  logic [AW-1:0]    sram_addr;
  word_t            sram_rdata;

  assign req_dec = decode(mem_req_addr_i);
  assign cur_dec = decode(addr_q);
  assign accept  = rst_ni && (state_q == IDLE) && mem_req_val_i;

  falafel_sram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk   (clk_i),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (mem_req_data_i),
    .rdata (sram_rdata)
  );

  // next-state, capture and storage control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    sram_we    = 1'b0;
    sram_addr  = AW'(req_dec.index);

    case (state_q)
      IDLE: begin
        if (accept) begin
          is_write_d = mem_req_is_write_i;
          addr_d     = mem_req_addr_i;
          data_d     = mem_req_data_i;
          sram_we    = mem_req_is_write_i && !req_dec.invalid;
          if (req_dec.invalid) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end else begin
            state_d    = RESPOND;
            rsp_data_d = rsp_value(mem_req_is_write_i, req_dec.invalid,
                                   mem_req_data_i, sram_rdata);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        sram_addr = AW'(cur_dec.index);
        if (cnt_q == CNT_W'(0)) begin
          state_d    = RESPOND;
          rsp_data_d = rsp_value(is_write_q, cur_dec.invalid, data_q, sram_rdata);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: begin
        if (mem_rsp_rdy_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESPOND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and response registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  assign mem_req_rdy_o  = rst_ni && (state_q == IDLE);
  assign mem_rsp_val_o  = (state_q == RESPOND);
  assign mem_rsp_data_o = rsp_data_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Directed scoreboard bench for falafel_mem_responder (LATENCY=2 and LATENCY=0 instances).
module tb_falafel_mem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          WORDS = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        val = 1'b0, is_write = 1'b0, rsp_rdy = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        req_rdy, rsp_val, err;
  logic [31:0] rsp_data;

  logic        val0 = 1'b0, is_write0 = 1'b0, rsp_rdy0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic        req_rdy0, rsp_val0, err0;
  logic [31:0] rsp_data0;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  falafel_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_req_val_i(val), .mem_req_rdy_o(req_rdy), .mem_req_is_write_i(is_write),
    .mem_req_addr_i(addr), .mem_req_data_i(wdata),
    .mem_rsp_val_o(rsp_val), .mem_rsp_rdy_i(rsp_rdy), .mem_rsp_data_o(rsp_data),
    .err_o(err)
  );

  falafel_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .mem_req_val_i(val0), .mem_req_rdy_o(req_rdy0), .mem_req_is_write_i(is_write0),
    .mem_req_addr_i(addr0), .mem_req_data_i(wdata0),
    .mem_rsp_val_o(rsp_val0), .mem_rsp_rdy_i(rsp_rdy0), .mem_rsp_data_o(rsp_data0),
    .err_o(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sb_pop();
    if (sb.size() == 0) return 32'hBAD0_BAD0;
    return sb.pop_front();
  endfunction

  // Issue one request on the LATENCY=2 instance; returns just after the acceptance edge.
  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_rdy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_rdy", {31'd0, req_rdy}, 32'd1);
    is_write = wr;
    addr     = a;
    wdata    = d;
    val      = 1'b1;
    @(posedge clk);
    #1;
    val = 1'b0;
  endtask

  // Wait for the response, optionally stall it, then complete and score it.
  task automatic get_rsp(input int hold, input int exp_lat);
    int          k;
    logic [31:0] d0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_val && k < 20);
    check("rsp_seen", {31'd0, rsp_val}, 32'd1);
    check("latency", 32'(k), 32'(exp_lat));
    d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      check("hold_val", {31'd0, rsp_val}, 32'd1);
      check("hold_data", rsp_data, d0);
      check("hold_req_rdy", {31'd0, req_rdy}, 32'd0);
      @(negedge clk);
    end
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1;
    rsp_rdy = 1'b0;
    check("rsp_data", d0, sb_pop());
    @(negedge clk);
    check("idle_req_rdy", {31'd0, req_rdy}, 32'd1);
    check("idle_rsp_val", {31'd0, rsp_val}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
    check("rst_rsp_val", {31'd0, rsp_val}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_req_rdy0", {31'd0, req_rdy0}, 32'd0);
    rst_n = 1'b1;

    // LATENCY=0 instance: write 5 then read it back
    @(negedge clk);
    check("l0_req_rdy", {31'd0, req_rdy0}, 32'd1);
    sb.push_back(32'd5);
    val0 = 1'b1; is_write0 = 1'b1; addr0 = BASE; wdata0 = 32'd5;
    @(posedge clk); #1; val0 = 1'b0;
    @(negedge clk);
    check("l0_wr_val", {31'd0, rsp_val0}, 32'd1);
    check("l0_wr_data", rsp_data0, sb_pop());
    rsp_rdy0 = 1'b1;
    @(posedge clk); #1; rsp_rdy0 = 1'b0;
    @(negedge clk);
    check("l0_idle", {31'd0, req_rdy0}, 32'd1);
    sb.push_back(32'd5);
    val0 = 1'b1; is_write0 = 1'b0; addr0 = BASE; wdata0 = 32'd0;
    @(posedge clk); #1; val0 = 1'b0;
    @(negedge clk);
    check("l0_rd_val", {31'd0, rsp_val0}, 32'd1);
    check("l0_rd_data", rsp_data0, sb_pop());
    check("l0_err", {31'd0, err0}, 32'd0);
    rsp_rdy0 = 1'b1;
    @(posedge clk); #1; rsp_rdy0 = 1'b0;

    // write then read BASE+8 with exact latency
    sb.push_back(32'hDEAD_BEEF);
    do_req(1'b1, BASE + 32'd8, 32'hDEAD_BEEF);
    get_rsp(0, 3);
    sb.push_back(32'hDEAD_BEEF);
    do_req(1'b0, BASE + 32'd8, 32'd0);
    get_rsp(0, 3);
    check("err_clean", {31'd0, err}, 32'd0);

    // backpressure: four stalled cycles in RESPOND
    sb.push_back(32'h0000_0011);
    do_req(1'b1, BASE, 32'h0000_0011);
    get_rsp(4, 3);

    // invalid accesses: out of range, misaligned, below base
    sb.push_back(32'd0);
    do_req(1'b0, BASE + 32'(WORDS * 4), 32'd0);
    get_rsp(0, 3);
    check("err_oor", {31'd0, err}, 32'd1);
    sb.push_back(32'd0);
    do_req(1'b1, BASE + 32'd2, 32'h0000_0055);
    get_rsp(0, 3);
    check("err_mis", {31'd0, err}, 32'd1);
    sb.push_back(32'd0);
    do_req(1'b0, BASE - 32'd4, 32'd0);
    get_rsp(0, 3);
    sb.push_back(32'h0000_0011);
    do_req(1'b0, BASE, 32'd0);
    get_rsp(0, 3);
    check("err_sticky", {31'd0, err}, 32'd1);

    // block store then block load at BASE+0x20
    sb.push_back(32'h0000_0040);
    do_req(1'b1, BASE + 32'h20, 32'h0000_0040);
    get_rsp(0, 3);
    sb.push_back(32'h0000_0100);
    do_req(1'b1, BASE + 32'h24, 32'h0000_0100);
    get_rsp(0, 3);
    sb.push_back(32'h0000_0040);
    do_req(1'b0, BASE + 32'h20, 32'd0);
    get_rsp(0, 3);
    sb.push_back(32'h0000_0100);
    do_req(1'b0, BASE + 32'h24, 32'd0);
    get_rsp(0, 3);

    // reset during WAIT after writing 7; a request offered during reset must be ignored
    do_req(1'b1, BASE + 32'd4, 32'd7);
    @(negedge clk);
    rst_n = 1'b0;
    val = 1'b1; is_write = 1'b1; addr = BASE + 32'd4; wdata = 32'h0000_0099;
    #1;
    check("rst_cycle_req_rdy", {31'd0, req_rdy}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dropped_rsp", {31'd0, rsp_val}, 32'd0);
    end
    check("err_after_rst", {31'd0, err}, 32'd0);
    sb.push_back(32'd7);
    do_req(1'b0, BASE + 32'd4, 32'd0);
    get_rsp(0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
